// File: rtl/parser_top_gen.sv
// Parser top: layer-0 parse state (shadow/active sets, packet-boundary commit) feeding LAYER_NUM chained Parser_Layer stages.
// Define PARSER_RULE_READBACK_EN to build the rule read path and the status register.

package parser_pkg;
    localparam int HEAD_WIDTH        = 32;
    localparam int META_WIDTH        = 32;
    localparam int TAG_WIDTH         = 4;
    localparam int TAG_VALID_BIT     = 0;
    localparam int TAG_START_BIT     = 1;
    localparam int TAG_TAIL_BIT      = 2;
    localparam int TYPE_OFFSET_WIDTH = 8;
    localparam int KEY_OFFSET_WIDTH  = 8;
    localparam int TYPE_NUM          = 4;
    localparam int KEY_FILED_NUM     = 8;
    localparam int TYPE_IDX_W        = $clog2(TYPE_NUM);
    localparam int KEY_IDX_W         = $clog2(KEY_FILED_NUM);

    typedef struct packed {
        logic [TYPE_NUM-1:0][TYPE_OFFSET_WIDTH-1:0]  type_offset;
        logic [KEY_FILED_NUM-1:0][KEY_OFFSET_WIDTH:0] key_offset;
        logic [7:0]                                  head_shift;
        logic [7:0]                                  meta_shift;
    } layer_info_t;
endpackage

module Parser_Layer
    import parser_pkg::*;
(
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_rule_wren,
    input  logic                            i_rule_rden,
    input  logic [2:0]                      i_rule_group,
    input  logic [5:0]                      i_rule_index,
    input  logic [31:0]                     i_rule_wdata,
    output logic                            o_rule_rdata_valid,
    output logic [31:0]                     o_rule_rdata,
    input  logic [HEAD_WIDTH+TAG_WIDTH-1:0] i_head,
    output logic [HEAD_WIDTH+TAG_WIDTH-1:0] o_head,
    input  logic [META_WIDTH+TAG_WIDTH-1:0] i_meta,
    output logic [META_WIDTH+TAG_WIDTH-1:0] o_meta
);
    logic [HEAD_WIDTH-1:0] mask;
    logic                  mask_sel;

    assign mask_sel = (i_rule_group == 3'd0) && (i_rule_index == 6'd0);

    // NOTE: all state, including rule registers, is reset so tags and readback start from a known value.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mask               <= '0;
            o_rule_rdata_valid <= 1'b0;
            o_rule_rdata       <= '0;
            o_head             <= '0;
            o_meta             <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            if (i_rule_wren && mask_sel) mask <= i_rule_wdata[HEAD_WIDTH-1:0];
            o_rule_rdata_valid <= i_rule_rden;
            o_rule_rdata       <= (i_rule_rden && mask_sel) ? mask : '0;
            o_head             <= {i_head[HEAD_WIDTH+TAG_WIDTH-1:TAG_WIDTH] ^ mask, i_head[TAG_WIDTH-1:0]};
            o_meta             <= i_meta;
        end
    end
endmodule

module parser_top_gen
    import parser_pkg::*;
#(
    parameter int LAYER_NUM  = 3,
    parameter int INFLIGHT_W = 8
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_rule_wren,
    input  logic                            i_rule_rden,
    input  logic [31:0]                     i_rule_addr,
    input  logic [31:0]                     i_rule_wdata,
    output logic                            o_rule_rdata_valid,
    output logic [31:0]                     o_rule_rdata,
    input  logic [HEAD_WIDTH+TAG_WIDTH-1:0] i_head,
    output logic [HEAD_WIDTH+TAG_WIDTH-1:0] o_head,
    input  logic [META_WIDTH+TAG_WIDTH-1:0] i_meta,
    output logic [META_WIDTH+TAG_WIDTH-1:0] o_meta,
    output logic                            o_commit_pending
);
    localparam int         HW         = HEAD_WIDTH + TAG_WIDTH;
    localparam int         MW         = META_WIDTH + TAG_WIDTH;
    localparam logic [3:0] TYPE_LIMIT = 4'(TYPE_NUM);
    localparam logic [5:0] KEY_LIMIT  = 6'(KEY_FILED_NUM);

    logic [7:0]            stage;
    logic [2:0]            group;
    logic [5:0]            index;
    logic                  stage0_wr, ctrl_set, commit_fire;
    logic                  commit_pending, in_pkt;
    logic                  in_valid, in_start, in_tail, eg_tail;
    logic [INFLIGHT_W-1:0] inflight;
    layer_info_t           shadow, active;

    assign stage     = i_rule_addr[31:24];
    assign group     = i_rule_addr[10:8];
    assign index     = i_rule_addr[5:0];
    assign stage0_wr = i_rule_wren && (stage == 8'd0);
    assign ctrl_set  = stage0_wr && (group == 3'd7) && i_rule_wdata[0];
    assign in_valid  = i_head[TAG_VALID_BIT];
    assign in_start  = i_head[TAG_START_BIT];
    assign in_tail   = i_head[TAG_TAIL_BIT];
    assign eg_tail   = o_head[TAG_VALID_BIT] && o_head[TAG_TAIL_BIT];

    // A commit never lands inside a packet nor on the first slice of a new one.
    assign commit_fire      = commit_pending && !in_pkt && !(in_valid && in_start);
    assign o_commit_pending = commit_pending;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shadow <= '0;
            active <= '0;
        end else begin
            if (commit_fire) active <= shadow;
            if (stage0_wr) begin
                case (group)
                    3'd2: if (index[3:0] < TYPE_LIMIT)
                              shadow.type_offset[index[TYPE_IDX_W-1:0]] <= i_rule_wdata[TYPE_OFFSET_WIDTH-1:0];
                    3'd3: if (index < KEY_LIMIT)
                              shadow.key_offset[index[KEY_IDX_W-1:0]] <=
                                  {i_rule_wdata[16], i_rule_wdata[KEY_OFFSET_WIDTH-1:0]};
                    3'd4: shadow.head_shift <= i_rule_wdata[7:0];
                    3'd5: shadow.meta_shift <= i_rule_wdata[7:0];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            commit_pending <= 1'b0;
            in_pkt         <= 1'b0;
            inflight       <= '0;
        end else begin
            commit_pending <= ctrl_set || (commit_pending && !commit_fire);
            if (in_valid) begin
                if (in_tail)       in_pkt <= 1'b0;
                else if (in_start) in_pkt <= 1'b1;
            end
            if (in_valid && in_start && !eg_tail && inflight != '1)
                inflight <= inflight + 1'b1;
            else if (eg_tail && !(in_valid && in_start) && inflight != '0)
                inflight <= inflight - 1'b1;
        end
    end

    // Layer-0 parse is combinational: shift, then type/key offsets selected from the shifted head.
    logic [HEAD_WIDTH-1:0] head0_data;
    logic [META_WIDTH-1:0] meta0_data;
    logic [TYPE_IDX_W-1:0] type_sel;
    logic [KEY_IDX_W-1:0]  key_sel;

    assign head0_data = i_head[HW-1:TAG_WIDTH] >> active.head_shift;
    assign type_sel   = head0_data[TYPE_IDX_W-1:0];
    assign key_sel    = head0_data[TYPE_IDX_W +: KEY_IDX_W];
    assign meta0_data = ((i_meta[MW-1:TAG_WIDTH] >> active.meta_shift)
                         + META_WIDTH'(active.type_offset[type_sel]))
                        ^ {active.key_offset[key_sel], {(META_WIDTH-KEY_OFFSET_WIDTH-1){1'b0}}};

    logic [HW-1:0]        head_chain [LAYER_NUM+1];
    logic [MW-1:0]        meta_chain [LAYER_NUM+1];
    logic [LAYER_NUM-1:0] layer_sel, layer_rden, layer_rv;
    logic [31:0]          layer_rd [LAYER_NUM];
    logic                 layer_rv_any;
    logic [31:0]          layer_rd_any;

    assign head_chain[0] = {head0_data, i_head[TAG_WIDTH-1:0]};
    assign meta_chain[0] = {meta0_data, i_meta[TAG_WIDTH-1:0]};

    for (genvar s = 0; s < LAYER_NUM; s++) begin : g_layer
        assign layer_sel[s] = (stage == 8'(s + 1));
        Parser_Layer u_layer (
            .i_clk              (i_clk),
            .i_rst_n            (i_rst_n),
            .i_rule_wren        (i_rule_wren && layer_sel[s]),
            .i_rule_rden        (layer_rden[s]),
            .i_rule_group       (group),
            .i_rule_index       (index),
            .i_rule_wdata       (i_rule_wdata),
            .o_rule_rdata_valid (layer_rv[s]),
            .o_rule_rdata       (layer_rd[s]),
            .i_head             (head_chain[s]),
            .o_head             (head_chain[s+1]),
            .i_meta             (meta_chain[s]),
            .o_meta             (meta_chain[s+1])
        );
    end

    assign o_head = head_chain[LAYER_NUM];
    assign o_meta = meta_chain[LAYER_NUM];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        layer_rv_any = |layer_rv;
        layer_rd_any = '0;
        for (int s = 0; s < LAYER_NUM; s++) layer_rd_any = layer_rd_any | layer_rd[s];
    end

    logic unused_ok;

`ifdef PARSER_RULE_READBACK_EN
    logic        local_rd, rd_valid_q;
    logic [31:0] local_data, rd_data_q;

    assign layer_rden = {LAYER_NUM{i_rule_rden}} & layer_sel;
    assign local_rd   = i_rule_rden && ((stage == 8'd0) || (stage > 8'(LAYER_NUM)));

    always_comb begin
        local_data = '0;
        if (stage == 8'd0) begin
            case (group)
                3'd2: if (index[3:0] < TYPE_LIMIT)
                          local_data[TYPE_OFFSET_WIDTH-1:0] = shadow.type_offset[index[TYPE_IDX_W-1:0]];
                3'd3: if (index < KEY_LIMIT) begin
                          local_data[KEY_OFFSET_WIDTH-1:0] =
                              shadow.key_offset[index[KEY_IDX_W-1:0]][KEY_OFFSET_WIDTH-1:0];
                          local_data[16] = shadow.key_offset[index[KEY_IDX_W-1:0]][KEY_OFFSET_WIDTH];
                      end
                3'd4: local_data[7:0] = shadow.head_shift;
                3'd5: local_data[7:0] = shadow.meta_shift;
                3'd6: local_data[INFLIGHT_W+7:0] = {commit_pending, 7'b0, inflight};
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= local_rd;
            rd_data_q  <= local_rd ? local_data : '0;
        end
    end

    assign o_rule_rdata_valid = rd_valid_q | layer_rv_any;
    assign o_rule_rdata       = rd_data_q | layer_rd_any;
    assign unused_ok          = ^{i_rule_addr[23:11], i_rule_addr[7:6]};
`else
    assign layer_rden         = '0;
    assign o_rule_rdata_valid = 1'b0;
    assign o_rule_rdata       = '0;
    assign unused_ok          = ^{i_rule_addr[23:11], i_rule_addr[7:6], i_rule_rden,
                                  layer_rv_any, layer_rd_any, inflight};
`endif
endmodule

// File: tb/tb_parser_top_gen.sv
// Scoreboard bench for parser_top_gen: the driver models commit/in-flight state and queues expected slices and
// read data; an independent monitor pops and compares whenever the DUT presents a valid slice or read response.

module tb_parser_top_gen;
    import parser_pkg::*;

    localparam int LN = 3;
    localparam int HW = HEAD_WIDTH + TAG_WIDTH;
    localparam int MW = META_WIDTH + TAG_WIDTH;
    localparam logic [3:0] T_IDLE = 4'b0000;
    localparam logic [3:0] T_S    = 4'b0011;
    localparam logic [3:0] T_M    = 4'b0001;
    localparam logic [3:0] T_T    = 4'b0101;
    localparam logic [3:0] T_ST   = 4'b0111;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rule_wren = 1'b0, rule_rden = 1'b0;
    logic [31:0]   rule_addr = '0, rule_wdata = '0;
    logic          rdata_valid;
    logic [31:0]   rdata;
    logic [HW-1:0] head_in = '0, head_out;
    logic [MW-1:0] meta_in = '0, meta_out;
    logic          commit_pending;

    parser_top_gen #(.LAYER_NUM(LN), .INFLIGHT_W(8)) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_rule_wren        (rule_wren),
        .i_rule_rden        (rule_rden),
        .i_rule_addr        (rule_addr),
        .i_rule_wdata       (rule_wdata),
        .o_rule_rdata_valid (rdata_valid),
        .o_rule_rdata       (rdata),
        .i_head             (head_in),
        .o_head             (head_out),
        .i_meta             (meta_in),
        .o_meta             (meta_out),
        .o_commit_pending   (commit_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [HW-1:0] head;
        logic [MW-1:0] meta;
    } exp_t;

    exp_t        slice_q[$];
    logic [31:0] rd_q[$];
    int          checks = 0;
    int          failures = 0;

    // Reference model state
    logic [7:0]  sh_type[4], ac_type[4];
    logic [8:0]  sh_key[8], ac_key[8];
    logic [7:0]  sh_hs, sh_ms, ac_hs, ac_ms;
    logic [31:0] lmask[LN];
    logic        m_pend, m_inpkt;
    int          m_infl;
    logic [3:0]  m_pipe[LN];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin sh_type[i] = '0; ac_type[i] = '0; end
        for (int i = 0; i < 8; i++) begin sh_key[i] = '0; ac_key[i] = '0; end
        for (int i = 0; i < LN; i++) begin lmask[i] = '0; m_pipe[i] = '0; end
        sh_hs = '0; sh_ms = '0; ac_hs = '0; ac_ms = '0;
        m_pend = 1'b0; m_inpkt = 1'b0; m_infl = 0;
    endtask

    task automatic step(input logic [3:0] tag, input logic [31:0] data, input logic [31:0] meta,
                        input logic wr, input logic rd, input logic [31:0] addr, input logic [31:0] wdata);
        logic [7:0]  stg;
        logic [2:0]  grp;
        logic [5:0]  idx;
        logic [31:0] h0, m0, rexp;
        logic        fire, vstart, eg;
        head_in = {data, tag}; meta_in = {meta, tag};
        rule_wren = wr; rule_rden = rd; rule_addr = addr; rule_wdata = wdata;
        stg = addr[31:24]; grp = addr[10:8]; idx = addr[5:0];
        if (tag[0]) begin
            h0 = data >> ac_hs;
            m0 = ((meta >> ac_ms) + {24'b0, ac_type[h0[1:0]]}) ^ ({23'b0, ac_key[h0[4:2]]} << 23);
            for (int s = 0; s < LN; s++) h0 = h0 ^ lmask[s];
            slice_q.push_back('{head: {h0, tag}, meta: {m0, tag}});
        end
`ifdef PARSER_RULE_READBACK_EN
        if (rd) begin
            rexp = '0;
            if (stg == 8'd0) begin
                case (grp)
                    3'd2: if (idx[3:0] < 4) rexp = {24'b0, sh_type[idx[1:0]]};
                    3'd3: if (idx < 8) rexp = {15'b0, sh_key[idx[2:0]][8], 8'b0, sh_key[idx[2:0]][7:0]};
                    3'd4: rexp = {24'b0, sh_hs};
                    3'd5: rexp = {24'b0, sh_ms};
                    3'd6: rexp = {16'b0, m_pend, 7'b0, 8'(m_infl)};
                    default: rexp = '0;
                endcase
            end else if (stg <= LN && grp == 3'd0 && idx == 6'd0) begin
                rexp = lmask[stg-1];
            end
            rd_q.push_back(rexp);
        end
`endif
        fire   = m_pend && !m_inpkt && !(tag[0] && tag[1]);
        vstart = tag[0] && tag[1];
        eg     = m_pipe[LN-1][0] && m_pipe[LN-1][2];
        @(posedge clk);
        if (fire) begin
            ac_type = sh_type; ac_key = sh_key; ac_hs = sh_hs; ac_ms = sh_ms;
        end
        m_pend = (wr && stg == 8'd0 && grp == 3'd7 && wdata[0]) || (m_pend && !fire);
        if (tag[0]) begin
            if (tag[2])      m_inpkt = 1'b0;
            else if (tag[1]) m_inpkt = 1'b1;
        end
        if (vstart && !eg && m_infl < 255) m_infl++;
        else if (eg && !vstart && m_infl > 0) m_infl--;
        for (int s = LN - 1; s > 0; s--) m_pipe[s] = m_pipe[s-1];
        m_pipe[0] = tag;
        if (wr && stg == 8'd0) begin
            case (grp)
                3'd2: if (idx[3:0] < 4) sh_type[idx[1:0]] = wdata[7:0];
                3'd3: if (idx < 8) sh_key[idx[2:0]] = {wdata[16], wdata[7:0]};
                3'd4: sh_hs = wdata[7:0];
                3'd5: sh_ms = wdata[7:0];
                default: ;
            endcase
        end else if (wr && stg <= LN && grp == 3'd0 && idx == 6'd0) begin
            lmask[stg-1] = wdata;
        end
        #1;
        check("commit_pending", commit_pending, m_pend);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(T_IDLE, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        step(T_IDLE, '0, '0, 1'b1, 1'b0, a, d);
    endtask
    task automatic rd(input logic [31:0] a);
        step(T_IDLE, '0, '0, 1'b0, 1'b1, a, '0);
    endtask
    task automatic slice(input logic [3:0] tag, input logic [31:0] d, input logic [31:0] m);
        step(tag, d, m, 1'b0, 1'b0, '0, '0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (head_out[0]) begin
            if (slice_q.size() == 0) check("unexpected_slice", head_out, '0);
            else begin
                e = slice_q.pop_front();
                check("o_head", head_out, e.head);
                check("o_meta", meta_out, e.meta);
            end
        end
        if (rdata_valid) begin
            if (rd_q.size() == 0) check("unexpected_rdata_valid", rdata_valid, 1'b0);
            else check("o_rule_rdata", rdata, rd_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        #12;
        check("reset_o_head", head_out, '0);
        check("reset_o_meta", meta_out, '0);
        check("reset_rdata_valid", rdata_valid, 1'b0);
        check("reset_rdata", rdata, '0);
        check("reset_commit_pending", commit_pending, 1'b0);
        @(posedge clk); #1; rst_n = 1'b1;

        // Layer masks, then readback of layer and stage-0 registers
        wr(32'h0100_0000, 32'h1111_0000);
        wr(32'h0200_0000, 32'h0000_2200);
        wr(32'h0300_0000, 32'h0000_0033);
        rd(32'h0300_0000);
        rd(32'h0200_0001);
        wr(32'h0000_0400, 32'd5);
        rd(32'h0000_0400);
        // Shadow headShift=5 not committed: this packet still uses shift 0
        slice(T_S, 32'hA5A5_0F01, 32'h0000_1000);
        slice(T_T, 32'h1234_5678, 32'h0000_2000);
        idle(2);

        wr(32'h0000_0201, 32'h10);
        wr(32'h0000_0205, 32'hEE);
        rd(32'h0000_0205);
        rd(32'h0000_0201);
        wr(32'h0000_0302, 32'h0001_0003);
        rd(32'h0000_0302);
        wr(32'h0000_0309, 32'h77);
        rd(32'h0000_0309);
        wr(32'h0000_0500, 32'd4);
        wr(32'h0000_0700, 32'd2);

        // Commit requested mid-packet applies only after the tail
        slice(T_S, 32'h0000_1111, 32'h0000_0100);
        step(T_M, 32'h0000_2222, 32'h0000_0200, 1'b1, 1'b0, 32'h0000_0700, 32'd1);
        slice(T_M, 32'h0000_3333, 32'h0000_0300);
        slice(T_T, 32'h0000_4444, 32'h0000_0400);
        idle(1);
        slice(T_ST, 32'hF000_0120, 32'h0000_0F00);
        idle(2);

        // Pending commit with a start slice arriving: deferred, packet uses old set
        wr(32'h0000_0400, 32'd1);
        wr(32'h0000_0700, 32'd1);
        slice(T_S, 32'h8000_00F0, 32'h0000_0050);
        slice(T_T, 32'h4000_0101, 32'h0000_0060);
        idle(1);
        slice(T_ST, 32'h8000_00F0, 32'h0000_0050);

        // Back-to-back single-slice packets hold off the commit until a gap
        wr(32'h0000_0400, 32'd2);
        step(T_ST, 32'h0000_00FF, 32'h0000_0011, 1'b1, 1'b0, 32'h0000_0700, 32'd1);
        slice(T_ST, 32'h0000_0F0F, 32'h0000_0022);
        slice(T_ST, 32'h0000_F0F0, 32'h0000_0033);
        idle(1);
        slice(T_ST, 32'h0000_00FF, 32'h0000_0011);

        // Control write in the commit cycle re-arms the pending flag
        wr(32'h0000_0400, 32'd3);
        wr(32'h0000_0700, 32'd1);
        wr(32'h0000_0700, 32'd1);
        idle(1);

        // In-flight count: four back-to-back packets, status read every cycle
        for (int i = 0; i < 4; i++)
            step(T_ST, 32'h0000_1000 + i, 32'h0000_0200 + i, 1'b0, 1'b1, 32'h0000_0600, '0);
        for (int i = 0; i < 5; i++) rd(32'h0000_0600);

        // Out-of-range stage: write dropped, read returns 0
        wr(32'h0900_0000, 32'hFFFF_FFFF);
        rd(32'h0900_0000);
        rd(32'h0100_0000);
        slice(T_ST, 32'hCAFE_0000, 32'h0000_0099);
        idle(4);

        // Reset mid-packet
        slice(T_S, 32'h0000_ABCD, 32'h0000_0001);
        slice(T_M, 32'h0000_BCDE, 32'h0000_0002);
        head_in = '0; meta_in = '0; rule_wren = 1'b0; rule_rden = 1'b0; rule_addr = '0; rule_wdata = '0;
        rst_n = 1'b0;
        model_reset();
        slice_q.delete();
        rd_q.delete();
        #2;
        check("midreset_o_head", head_out, '0);
        check("midreset_o_meta", meta_out, '0);
        check("midreset_rdata_valid", rdata_valid, 1'b0);
        check("midreset_commit_pending", commit_pending, 1'b0);
        @(posedge clk); #1; rst_n = 1'b1;
        rd(32'h0000_0600);
        rd(32'h0000_0400);
        slice(T_ST, 32'h0000_7777, 32'h0000_0777);
        idle(6);

        check("slice_queue_drained", slice_q.size(), 0);
        check("read_queue_drained", rd_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/parser_top_gen.md
# parser_top_gen

Parametrised successor of the fixed three-layer parser top. It chains `LAYER_NUM` `Parser_Layer` instances in a generate loop and owns the layer-0 initial parse state (type offsets, key offsets, head/meta shift). Rule writes go to a shadow copy and are committed atomically on a packet boundary, so a rule update never splits a packet. The block sits between packet ingress (head/meta slices) and the downstream key-extract/lookup stage.

## Interface
Parameters:
- `LAYER_NUM`, 3: number of chained `Parser_Layer` stages; legal range 1..8.
- `INFLIGHT_W`, 8: width of the saturating in-flight packet counter.

Ports:
- `i_clk`  in  1  core clock.
- `i_rst_n`  in  1  reset; one clock, reset is asynchronous and active-low.
- `i_rule_wren`  in  1  rule write strobe.
- `i_rule_rden`  in  1  rule read strobe.
- `i_rule_addr`  in  32  [31:24] stage select (0 = layer-0 state, 1..LAYER_NUM = parser stage); [10:8] register group; [5:0] index.
- `i_rule_wdata`  in  32  write data.
- `o_rule_rdata_valid`  out  1  read data valid.
- `o_rule_rdata`  out  32  read data.
- `i_head`  in  HEAD_WIDTH+TAG_WIDTH  head slice with tag.
- `o_head`  out  HEAD_WIDTH+TAG_WIDTH  parsed head slice.
- `i_meta`  in  META_WIDTH+TAG_WIDTH  meta slice with tag.
- `o_meta`  out  META_WIDTH+TAG_WIDTH  parsed meta slice.
- `o_commit_pending`  out  1  shadow commit requested but not yet applied.

## Operation
- Stage 0 groups (addr[31:24]==0, addr[10:8]):
  - 2: `type_offset[addr[3:0]]` <= wdata[TYPE_OFFSET_WIDTH-1:0].
  - 3: `key_offset[addr[5:0]]` <= {wdata[16], wdata[KEY_OFFSET_WIDTH-1:0]}.
  - 4: `headShift`.
  - 5: `metaShift`.
  - 6: status, read-only: {commit_pending, 7'b0, inflight[INFLIGHT_W-1:0]}, zero-extended.
  - 7: control; wdata[0]=1 sets commit_pending.
- Groups 2-5 write the shadow set. The active set drives `layer_info_0` for every slice. Indices ≥ TYPE_NUM / KEY_FILED_NUM are ignored.
- Writes with addr[31:24] in 1..LAYER_NUM go to that `Parser_Layer`. Writes with any other stage value are dropped silently.
- Ingress framing: `in_pkt` is set by a valid slice with `TAG_START_BIT` and cleared by a valid slice with `TAG_TAIL_BIT`. A slice with both start and tail set is a single-slice packet and leaves `in_pkt` at 0.
- Commit: when commit_pending=1, `in_pkt`=0, and the current `i_head` is not a valid start slice, copy shadow to active and clear commit_pending in that cycle.
  - The active set is unchanged throughout any packet.
  - A control write that coincides with the commit cycle leaves commit_pending=1 for a second commit.
- In-flight counter:
  - +1 on a valid ingress start slice; -1 on a valid egress (`o_head`) tail slice.
  - Simultaneous increment and decrement leaves the count unchanged.
  - Saturates at all-ones and does not decrement below 0.

## Timing
- Reset state: active and shadow sets 0, commit_pending 0, in_pkt 0, inflight 0, `o_rule_rdata_valid` 0, `o_rule_rdata` 0. Pipeline valid tags at `o_head`/`o_meta` are 0.
- Head/meta latency: LAYER_NUM × per-layer latency. Stage 0 adds no cycle.
- Writes take effect on the clock edge after the strobe (shadow, stage register, or pending flag).
- Stage-0 reads return data 1 cycle after `i_rule_rden`. A same-cycle write to the same address returns the old value.
- Stage 1..N reads forward `i_rule_rden` to the selected layer only. The layers' rdata_valid/rdata are OR-combined onto the outputs.
- A read to an out-of-range stage returns valid with data 0 one cycle later.
- Reset asserted mid-packet clears everything above. A packet partially in the pipe is lost and its tail does not decrement the counter below 0.

## Configuration
- `PARSER_RULE_READBACK_EN`:
  - Defined: read path as described above.
  - Undefined: `i_rule_rden` is ignored, `o_rule_rdata_valid` and `o_rule_rdata` are tied 0, layers receive rden=0, and the status register is not built. The write, commit and datapath behaviour is identical in both cases.

## Test plan
- Write shadow headShift=5, then read addr 0x0000_0400 -> rdata=5, but `o_head` of the next packet still uses headShift 0 until a commit is issued.
- Start a 4-slice packet, write control wdata=1 at slice 2 -> commit_pending stays 1 until the cycle after the tail slice, then drops and the next packet uses the new offsets.
- Commit request in the same cycle as a valid start slice with in_pkt=0 -> commit deferred at least one cycle; that packet uses the old set.
- Single-slice packet (start+tail) back-to-back with commit pending -> in_pkt stays 0 and the commit lands in the first gap cycle.
- Send 3 packets with LAYER_NUM=3 -> status inflight peaks at 3 and returns to 0 after the last egress tail; ingress start and egress tail in the same cycle keep the count unchanged.
- Write to stage 9 with LAYER_NUM=3 -> no layer state changes; a read of stage 9 returns valid with 0 after 1 cycle. Reset mid-packet -> all status, outputs and valid tags are 0.
